mac_operand_pairer: RTL and testbench
=====================================

MAC_OPERAND_PAIRER -- requirements
Module: mac_operand_pairer

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits for a, b, out_a and out_b.
REQ-002 Parameter DEPTH, default 4: entries per operand FIFO; power of two, at least 2.
REQ-003 Parameter CW = log2(DEPTH)+1, derived, not overridable: width of the occupancy counts.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  synchronous discard of all buffered operands.
REQ-007 a  input  WIDTH  operand A data.
REQ-008 valid_a  input  1  operand A valid.
REQ-009 ready_a  output  1  A FIFO can accept a word.
REQ-010 b  input  WIDTH  operand B data.
REQ-011 valid_b  input  1  operand B valid.
REQ-012 ready_b  output  1  B FIFO can accept a word.
REQ-013 out_a  output  WIDTH  head of the A FIFO.
REQ-014 out_b  output  WIDTH  head of the B FIFO.
REQ-015 valid_o  output  1  a complete A/B pair is presented.
REQ-016 ready_o  input  1  downstream MAC accepts the pair.
REQ-017 count_a  output  CW  A FIFO occupancy, 0..DEPTH.
REQ-018 count_b  output  CW  B FIFO occupancy, 0..DEPTH.
REQ-019 pair_cnt  output  16  running count of pairs delivered.

Function
REQ-020 A and B SHALL each be buffered in an independent DEPTH-entry FIFO, so the two streams may arrive with arbitrary relative skew.
REQ-021 A push SHALL occur when valid_a && ready_a && !flush; a B push SHALL follow the same rule with the B signals.
REQ-022 ready_a SHALL equal (count_a < DEPTH) && !flush, and ready_b SHALL equal (count_b < DEPTH) && !flush.
REQ-023 ready_a and ready_b SHALL NOT depend combinationally on ready_o; a full FIFO refuses a push even in a cycle where it pops.
REQ-024 valid_o SHALL equal (count_a != 0) && (count_b != 0) && !flush.
REQ-025 out_a and out_b SHALL be show-ahead: they present the FIFO heads, driven from registers only.
REQ-026 When valid_o is low, out_a and out_b SHALL hold their last values.
REQ-027 A pop SHALL occur when valid_o && ready_o; it removes one entry from both FIFOs in the same cycle.
REQ-028 There SHALL be no partial pops: an entry in one FIFO is never removed without its partner.
REQ-029 Latency: a word pushed at edge N SHALL be visible on out_a/out_b after edge N, with valid_o high once its partner is also present.
REQ-030 Push and pop in the same cycle on one FIFO SHALL leave its count unchanged, and the data order SHALL be preserved (FIFO order).
REQ-031 Read and write pointers SHALL wrap modulo DEPTH; counts SHALL never exceed DEPTH and never underflow.
REQ-032 pair_cnt SHALL increment by 1 on each pop and wrap from 0xFFFF to 0x0000.
REQ-033 flush high at an edge SHALL clear both FIFOs' pointers and counts.
REQ-034 In a flush cycle, pushes and pops SHALL be ignored; flush takes priority over every other event.
REQ-035 flush SHALL NOT change pair_cnt.
REQ-036 Operand contents SHALL never be transformed: out_a and out_b are bit-exact copies of the accepted a and b.

Reset
REQ-037 While rst_n is low: count_a = count_b = 0, all pointers = 0, valid_o = 0, pair_cnt = 0, out_a = out_b = 0.
REQ-038 While rst_n is low, ready_a and ready_b SHALL be 0; both SHALL rise to 1 on the first cycle after rst_n deasserts.
REQ-039 Reset asserted mid-operation SHALL discard all buffered data immediately, without waiting for a clock edge.
REQ-040 FIFO storage arrays need not be reset, but their contents SHALL be unobservable until written.

Verification
REQ-041 Skew: push A = 0x1111, 0x2222, 0x3333 with B idle, then push B = 0x000A, 0x000B, 0x000C, ready_o = 1 -> pairs (0x1111, 0x000A), (0x2222, 0x000B), (0x3333, 0x000C) in order, pair_cnt = 3.
REQ-042 Full, DEPTH = 4: push 5 A words with B idle -> ready_a = 0 after the 4th push, 5th word held off, count_a = 4, valid_o = 0.
REQ-043 Backpressure: both FIFOs at 2 entries, ready_o = 0 for 3 cycles -> out_a/out_b stable, counts stay 2; ready_o = 1 -> 2 pops on consecutive cycles.
REQ-044 Simultaneous: count_a = 2, push A and pop in the same cycle -> count_a remains 2, output order correct.
REQ-045 Flush/reset: 3 A + 1 B buffered with flush = 1 and valid_a = 1 -> counts 0, valid_o = 0, pair_cnt unchanged; repeat with rst_n pulsed low mid-cycle -> all outputs 0 asynchronously.
REQ-046 Wrap: preload pair_cnt to 0xFFFE via 0xFFFE pops, then 2 more pops -> pair_cnt = 0x0000.

Source files
------------

// File: rtl/mac_operand_pairer.sv
// -----------------------------------------------------------------------------
// mac_operand_pairer
//
// Purpose:
//   Pairs two independently arriving operand streams (A and B) for a
//   downstream multiply-accumulate unit. Each stream is buffered in its own
//   DEPTH-entry FIFO, so A and B may arrive with any relative skew. A pair is
//   offered once both FIFOs hold at least one word. An accepted pair removes
//   the head of both FIFOs together.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   flush     in   synchronous discard of all buffered operands
//   a/valid_a in   operand A word and its valid
//   ready_a   out  A FIFO can take a word this cycle
//   b/valid_b in   operand B word and its valid
//   ready_b   out  B FIFO can take a word this cycle
//   out_a     out  registered head of the A FIFO
//   out_b     out  registered head of the B FIFO
//   valid_o   out  a complete A/B pair is presented
//   ready_o   in   downstream accepts the presented pair
//   count_a   out  A FIFO occupancy, 0..DEPTH
//   count_b   out  B FIFO occupancy, 0..DEPTH
//   pair_cnt  out  running count of delivered pairs (wraps at 16 bits)
// -----------------------------------------------------------------------------
module mac_operand_pairer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic             valid_a,
  output logic             ready_a,
  input  logic [WIDTH-1:0] b,
  input  logic             valid_b,
  output logic             ready_b,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             valid_o,
  input  logic             ready_o,
  output logic [CW-1:0]    count_a,
  output logic [CW-1:0]    count_b,
  output logic [15:0]      pair_cnt
);

  // Lane 0 carries operand A, lane 1 carries operand B.
  logic [1:0][WIDTH-1:0] lane_din;
  logic [1:0]            lane_valid;

  assign lane_din   = {b, a};
  assign lane_valid = {valid_b, valid_a};

  // Held low through reset and for the first edge after it, so neither
  // input port advertises space while the block is still coming out of reset.
  logic rst_done_q;
  logic rst_done_d;

  logic [15:0] pair_cnt_q;
  logic [15:0] pair_cnt_d;

  // A pop is common to both lanes: partial pops are impossible by construction.
  logic pop;

  assign valid_o = (count_a != '0) && (count_b != '0) && !flush;
  assign pop     = valid_o && ready_o;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      // Storage is not reset; an entry is only ever read after being written,
      // because the head register is loaded from the bypass path or from a
      // slot that lies between the read and write pointers.
      logic [WIDTH-1:0] mem_q [DEPTH];

      logic [PW-1:0]    wr_ptr_q;
      logic [PW-1:0]    wr_ptr_d;
      logic [PW-1:0]    rd_ptr_q;
      logic [PW-1:0]    rd_ptr_d;
      logic [CW-1:0]    count_q;
      logic [CW-1:0]    count_d;
      logic [WIDTH-1:0] head_q;
      logic [WIDTH-1:0] head_d;
      logic [CW-1:0]    remain;
      logic             ready;
      logic             push;

      // Readiness looks only at this lane's own occupancy, never at ready_o,
      // so a full FIFO refuses a push even in a cycle where it pops.
      assign ready = rst_done_q && (count_q < CW'(DEPTH)) && !flush;
      assign push  = lane_valid[gi] && ready;

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        remain   = count_q - CW'(pop);

        if (flush) begin
          // Flush wins over everything; the head register keeps its value.
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end else begin
          // Pointers are PW bits wide, so they wrap modulo DEPTH for free.
          wr_ptr_d = wr_ptr_q + PW'(push);
          rd_ptr_d = rd_ptr_q + PW'(pop);
          count_d  = count_q + CW'(push) - CW'(pop);

          // Next head: an older entry survives the pop -> read it from
          // storage; otherwise the word being pushed becomes the head
          // directly; with nothing left, the output holds.
          if (remain != '0) begin
            head_d = mem_q[rd_ptr_d];
          end else if (push) begin
            head_d = lane_din[gi];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
          head_q   <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
          head_q   <= head_d;
        end
      end

      always_ff @(posedge clk) begin
        if (push) begin
          mem_q[wr_ptr_q] <= lane_din[gi];
        end
      end
    end
  endgenerate

  assign ready_a = g_lane[0].ready;
  assign ready_b = g_lane[1].ready;
  assign count_a = g_lane[0].count_q;
  assign count_b = g_lane[1].count_q;
  assign out_a   = g_lane[0].head_q;
  assign out_b   = g_lane[1].head_q;

  always_comb begin
    rst_done_d = 1'b1;
    pair_cnt_d = pair_cnt_q;
    // pop is already suppressed during flush, so flush never moves the count.
    if (pop) begin
      pair_cnt_d = pair_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done_q <= 1'b0;
      pair_cnt_q <= '0;
    end else begin
      rst_done_q <= rst_done_d;
      pair_cnt_q <= pair_cnt_d;
    end
  end

  assign pair_cnt = pair_cnt_q;

endmodule

// File: tb/tb_mac_operand_pairer.sv
// -----------------------------------------------------------------------------
// tb_mac_operand_pairer
//
// Directed bench for mac_operand_pairer (WIDTH = 16, DEPTH = 4). Inputs are
// changed 1 ns after a rising edge and outputs are sampled there too, so
// every check sees settled post-edge state.
// -----------------------------------------------------------------------------
module tb_mac_operand_pairer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [WIDTH-1:0] a;
  logic             valid_a;
  logic             ready_a;
  logic [WIDTH-1:0] b;
  logic             valid_b;
  logic             ready_b;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             valid_o;
  logic             ready_o;
  logic [CW-1:0]    count_a;
  logic [CW-1:0]    count_b;
  logic [15:0]      pair_cnt;

  int n_cmp;
  int n_err;

  mac_operand_pairer #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .a       (a),
    .valid_a (valid_a),
    .ready_a (ready_a),
    .b       (b),
    .valid_b (valid_b),
    .ready_b (ready_b),
    .out_a   (out_a),
    .out_b   (out_b),
    .valid_o (valid_o),
    .ready_o (ready_o),
    .count_a (count_a),
    .count_b (count_b),
    .pair_cnt(pair_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    flush   = 1'b0;
    a       = '0;
    b       = '0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    ready_o = 1'b0;

    // ---------------- reset state ----------------
    step();
    step();
    check("rst_count_a", 32'(count_a), 32'd0);
    check("rst_count_b", 32'(count_b), 32'd0);
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_ready_a", 32'(ready_a), 32'd0);
    check("rst_ready_b", 32'(ready_b), 32'd0);
    check("rst_out_a", 32'(out_a), 32'd0);
    check("rst_pair_cnt", 32'(pair_cnt), 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_ready_a", 32'(ready_a), 32'd1);
    check("post_rst_ready_b", 32'(ready_b), 32'd1);

    // ---------------- skew: 3 A words, then 3 B words ----------------
    valid_a = 1'b1;
    a = 16'h1111; step();
    a = 16'h2222; step();
    a = 16'h3333; step();
    valid_a = 1'b0;
    check("skew_count_a", 32'(count_a), 32'd3);
    check("skew_valid_o_idle_b", 32'(valid_o), 32'd0);
    valid_b = 1'b1;
    b = 16'h000A; step();
    b = 16'h000B; step();
    b = 16'h000C; step();
    valid_b = 1'b0;
    check("skew_count_b", 32'(count_b), 32'd3);
    check("skew_valid_o", 32'(valid_o), 32'd1);
    ready_o = 1'b1;
    check("skew_p1_a", 32'(out_a), 32'h1111);
    check("skew_p1_b", 32'(out_b), 32'h000A);
    step();
    check("skew_p2_a", 32'(out_a), 32'h2222);
    check("skew_p2_b", 32'(out_b), 32'h000B);
    step();
    check("skew_p3_a", 32'(out_a), 32'h3333);
    check("skew_p3_b", 32'(out_b), 32'h000C);
    step();
    check("skew_pair_cnt", 32'(pair_cnt), 32'd3);
    check("skew_empty_valid_o", 32'(valid_o), 32'd0);
    check("skew_hold_a", 32'(out_a), 32'h3333);
    check("skew_hold_b", 32'(out_b), 32'h000C);
    ready_o = 1'b0;

    // ---------------- full: 5 A pushes into a 4-deep FIFO ----------------
    valid_a = 1'b1;
    a = 16'hA001; step();
    a = 16'hA002; step();
    a = 16'hA003; step();
    check("full_ready_a_at3", 32'(ready_a), 32'd1);
    a = 16'hA004; step();
    check("full_ready_a_at4", 32'(ready_a), 32'd0);
    a = 16'hA005; step();
    valid_a = 1'b0;
    check("full_count_a", 32'(count_a), 32'd4);
    check("full_valid_o", 32'(valid_o), 32'd0);
    flush = 1'b1;
    #1;
    check("flush_ready_a_low", 32'(ready_a), 32'd0);
    step();
    flush = 1'b0;
    check("full_flush_count_a", 32'(count_a), 32'd0);

    // ---------------- backpressure: 2 + 2, ready_o low 3 cycles ----------------
    valid_a = 1'b1;
    valid_b = 1'b1;
    a = 16'hC001; b = 16'hD001; step();
    a = 16'hC002; b = 16'hD002; step();
    valid_a = 1'b0;
    valid_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp_hold%0d_a", i), 32'(out_a), 32'hC001);
      check($sformatf("bp_hold%0d_b", i), 32'(out_b), 32'hD001);
      check($sformatf("bp_hold%0d_cnt", i), 32'(count_a), 32'd2);
    end
    ready_o = 1'b1;
    step();
    check("bp_pop1_count_b", 32'(count_b), 32'd1);
    check("bp_pop1_a", 32'(out_a), 32'hC002);
    check("bp_pop1_b", 32'(out_b), 32'hD002);
    step();
    check("bp_pop2_count_a", 32'(count_a), 32'd0);
    check("bp_pair_cnt", 32'(pair_cnt), 32'd5);
    ready_o = 1'b0;

    // ---------------- simultaneous push and pop ----------------
    valid_a = 1'b1;
    valid_b = 1'b1;
    a = 16'hE001; b = 16'hF001; step();
    a = 16'hE002; b = 16'hF002; step();
    valid_b = 1'b0;
    ready_o = 1'b1;
    a = 16'hE003; step();
    valid_a = 1'b0;
    check("sim_count_a", 32'(count_a), 32'd2);
    check("sim_count_b", 32'(count_b), 32'd1);
    check("sim_out_a", 32'(out_a), 32'hE002);
    check("sim_out_b", 32'(out_b), 32'hF002);
    valid_b = 1'b1;
    b = 16'hF003; step();
    valid_b = 1'b0;
    check("sim_next_a", 32'(out_a), 32'hE003);
    check("sim_next_b", 32'(out_b), 32'hF003);
    step();
    check("sim_drained", 32'(count_a), 32'd0);
    check("sim_pair_cnt", 32'(pair_cnt), 32'd8);
    ready_o = 1'b0;

    // ---------------- flush with 3 A + 1 B buffered ----------------
    valid_a = 1'b1;
    valid_b = 1'b1;
    a = 16'h5001; b = 16'h6001; step();
    valid_b = 1'b0;
    a = 16'h5002; step();
    a = 16'h5003; step();
    check("fl_pre_count_a", 32'(count_a), 32'd3);
    check("fl_pre_valid_o", 32'(valid_o), 32'd1);
    flush = 1'b1;
    ready_o = 1'b1;
    a = 16'h5004;
    #1;
    check("fl_valid_o_comb", 32'(valid_o), 32'd0);
    step();
    flush = 1'b0;
    valid_a = 1'b0;
    ready_o = 1'b0;
    check("fl_count_a", 32'(count_a), 32'd0);
    check("fl_count_b", 32'(count_b), 32'd0);
    check("fl_valid_o", 32'(valid_o), 32'd0);
    check("fl_pair_cnt", 32'(pair_cnt), 32'd8);

    // ---------------- asynchronous reset mid-cycle ----------------
    valid_a = 1'b1;
    valid_b = 1'b1;
    a = 16'h7001; b = 16'h8001; step();
    valid_b = 1'b0;
    a = 16'h7002; step();
    valid_a = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_count_a", 32'(count_a), 32'd0);
    check("ar_count_b", 32'(count_b), 32'd0);
    check("ar_valid_o", 32'(valid_o), 32'd0);
    check("ar_out_a", 32'(out_a), 32'd0);
    check("ar_out_b", 32'(out_b), 32'd0);
    check("ar_pair_cnt", 32'(pair_cnt), 32'd0);
    check("ar_ready_a", 32'(ready_a), 32'd0);
    rst_n = 1'b1;
    step();
    check("ar_ready_back", 32'(ready_a), 32'd1);

    // ---------------- pair_cnt wrap ----------------
    valid_a = 1'b1;
    valid_b = 1'b1;
    ready_o = 1'b1;
    guard = 0;
    while (pair_cnt != 16'hFFFE && guard < 70000) begin
      a = 16'(guard);
      b = 16'(~guard);
      step();
      guard++;
    end
    check("wrap_reached", 32'(guard < 70000), 32'd1);
    check("wrap_fffe", 32'(pair_cnt), 32'hFFFE);
    step();
    valid_a = 1'b0;
    valid_b = 1'b0;
    check("wrap_ffff", 32'(pair_cnt), 32'hFFFF);
    step();
    ready_o = 1'b0;
    check("wrap_zero", 32'(pair_cnt), 32'h0000);
    check("wrap_empty", 32'(valid_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
